// File: rtl/id_regfile_pipe_if.sv
// IF->ID and ID->EX handshake/bus bundle for id_regfile_pipe, plus write-back and flush inputs.
// slave = the decode stage, master = whoever drives it (IF/WB/EX side).
interface id_regfile_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       ins;
  logic [31:0]       npc_i;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_op;
  logic [5:0]        out_func;
  logic [DATA_W-1:0] out_data_a;
  logic [DATA_W-1:0] out_data_b;
  logic [ADDR_W-1:0] out_dst;
  logic [DATA_W-1:0] out_simm;
  logic [DATA_W-1:0] out_zimm;
  logic [25:0]       out_jpc;
  logic [31:0]       out_npc;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_load_wb;

  modport slave (
    input  in_valid, ins, npc_i, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_op, out_func, out_data_a, out_data_b, out_dst,
           out_simm, out_zimm, out_jpc, out_npc, out_mem_read, out_mem_write, out_load_wb
  );

  modport master (
    output in_valid, ins, npc_i, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_op, out_func, out_data_a, out_data_b, out_dst,
           out_simm, out_zimm, out_jpc, out_npc, out_mem_read, out_mem_write, out_load_wb
  );
endinterface

// File: rtl/id_regfile_pipe.sv
// Decode stage: regfile with WB bypass, 1-cycle registered ID/EX slot, one bubble per load-use; holds while !out_ready.
// Optional macro ID_STALL_COUNTER_EN adds a 32-bit stall_count output counting hazard bubble cycles.
module id_regfile_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  id_regfile_pipe_if.slave  bus
`ifdef ID_STALL_COUNTER_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  typedef struct packed {
    logic [5:0]        op;
    logic [5:0]        func;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;
    logic [25:0]       jpc;
    logic [31:0]       npc;
    logic              mem_read;
    logic              mem_write;
    logic              load_wb;
  } entry_t;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  entry_t            entry_d, entry_q, dec;
  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] rs_fld, rt_fld, rd_fld;
  logic [DATA_W-1:0] opa, opb;
  logic              wb_we, hazard, in_ready, accept;

  assign rs_fld = bus.ins[21 +: ADDR_W];
  assign rt_fld = bus.ins[16 +: ADDR_W];
  assign rd_fld = bus.ins[11 +: ADDR_W];
  assign wb_we  = bus.wb_en && (bus.wb_addr != '0);

  // Same-cycle write-back wins over the (not yet written) regfile contents.
  assign opa = (rs_fld == '0) ? '0 :
               (bus.wb_en && bus.wb_addr == rs_fld) ? bus.wb_data : regs_q[rs_fld];
  assign opb = (rt_fld == '0) ? '0 :
               (bus.wb_en && bus.wb_addr == rt_fld) ? bus.wb_data : regs_q[rt_fld];

  assign hazard   = valid_q && entry_q.mem_read && (entry_q.dst != '0) &&
                    ((entry_q.dst == rs_fld) || (entry_q.dst == rt_fld));
  assign in_ready = !bus.flush && !hazard && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    dec        = '0;
    dec.op     = bus.ins[31:26];
    dec.func   = bus.ins[5:0];
    dec.data_a = opa;
    dec.data_b = opb;
    dec.rs     = rs_fld;
    dec.rt     = rt_fld;
    dec.simm   = DATA_W'($signed(bus.ins[15:0]));
    dec.zimm   = DATA_W'(bus.ins[15:0]);
    dec.jpc    = bus.ins[25:0];
    dec.npc    = bus.npc_i;
    casez (bus.ins[31:26])
      6'b000000, 6'b011100: dec.dst = rd_fld;
      6'b010000, 6'b001???: dec.dst = rt_fld;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec.dst      = rt_fld;
        dec.mem_read = 1'b1;
        dec.load_wb  = 1'b1;
      end
      6'b101000, 6'b101001, 6'b101011: dec.mem_write = 1'b1;
      6'b000011, 6'b000001: dec.dst = {ADDR_W{1'b1}};
      default: ;
    endcase
  end

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      entry_d = dec;
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      // A held entry must not miss a write-back to its sources.
      if (wb_we && bus.wb_addr == entry_q.rs) entry_d.data_a = bus.wb_data;
      if (wb_we && bus.wb_addr == entry_q.rt) entry_d.data_b = bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

`ifdef ID_STALL_COUNTER_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hazard && bus.out_ready && !bus.flush) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_op        = entry_q.op;
  assign bus.out_func      = entry_q.func;
  assign bus.out_data_a    = entry_q.data_a;
  assign bus.out_data_b    = entry_q.data_b;
  assign bus.out_dst       = entry_q.dst;
  assign bus.out_simm      = entry_q.simm;
  assign bus.out_zimm      = entry_q.zimm;
  assign bus.out_jpc       = entry_q.jpc;
  assign bus.out_npc       = entry_q.npc;
  assign bus.out_mem_read  = entry_q.mem_read;
  assign bus.out_mem_write = entry_q.mem_write;
  assign bus.out_load_wb   = entry_q.load_wb;

endmodule

// File: tb/tb_id_regfile_pipe.sv
// Directed bench for id_regfile_pipe: bypass, load-use bubble, held-entry WB update, immediates, flush, async reset.
module tb_id_regfile_pipe;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
`ifdef ID_STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  id_regfile_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  id_regfile_pipe #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ID_STALL_COUNTER_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ins       = '0;
    bus.npc_i     = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_data_a", bus.out_data_a, 0);
    check("rst_dst", bus.out_dst, 0);

    // Bypass: r5 written in the same cycle ADDU r3,r5,r0 is decoded.
    @(negedge clk);
    rst         = 1'b0;
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd5;
    bus.wb_data = 32'h1234;
    bus.in_valid = 1'b1;
    bus.ins     = rtype(6'h00, 5'd5, 5'd0, 5'd3, 6'h21);
    bus.npc_i   = 32'h100;
    @(negedge clk);
    check("byp_valid", bus.out_valid, 1);
    check("byp_data_a", bus.out_data_a, 64'h1234);
    check("byp_data_b", bus.out_data_b, 0);
    check("byp_dst", bus.out_dst, 3);
    check("byp_npc", bus.out_npc, 64'h100);
    check("byp_func", bus.out_func, 64'h21);

    // r0 write ignored; r5 now read from the regfile.
    bus.wb_addr = 5'd0;
    bus.wb_data = 32'hFFFF;
    bus.ins     = rtype(6'h00, 5'd0, 5'd5, 5'd4, 6'h21);
    @(negedge clk);
    check("r0_data_a", bus.out_data_a, 0);
    check("r0_data_b", bus.out_data_b, 64'h1234);
    check("r0_dst", bus.out_dst, 4);

    bus.wb_addr  = 5'd2;
    bus.wb_data  = 32'h22;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("idle_valid", bus.out_valid, 0);

    // Load-use: LW r8,0(r1) then ADDU r9,r8,r2.
    bus.wb_en    = 1'b0;
    bus.in_valid = 1'b1;
    bus.ins      = itype(6'h23, 5'd1, 5'd8, 16'h0000);
    @(negedge clk);
    check("lw_valid", bus.out_valid, 1);
    check("lw_mem_read", bus.out_mem_read, 1);
    check("lw_load_wb", bus.out_load_wb, 1);
    check("lw_dst", bus.out_dst, 8);
    bus.ins = rtype(6'h00, 5'd8, 5'd2, 5'd9, 6'h21);
    #1;
    check("haz_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("bubble_valid", bus.out_valid, 0);
    check("bubble_in_ready", bus.in_ready, 1);
`ifdef ID_STALL_COUNTER_EN
    check("stall_count", stall_count, 1);
`endif
    @(negedge clk);
    check("use_valid", bus.out_valid, 1);
    check("use_dst", bus.out_dst, 9);
    check("use_data_b", bus.out_data_b, 64'h22);
    check("use_mem_read", bus.out_mem_read, 0);

    // Held entry ADDU r3,r4,r6 picks up a write-back to r6.
    bus.ins = rtype(6'h00, 5'd4, 5'd6, 5'd3, 6'h21);
    @(negedge clk);
    check("hold_acc_valid", bus.out_valid, 1);
    check("hold_acc_data_b", bus.out_data_b, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.wb_en     = 1'b1;
    bus.wb_addr   = 5'd6;
    bus.wb_data   = 32'hABCD;
    #1;
    check("hold_in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.wb_en = 1'b0;
    check("hold_data_b", bus.out_data_b, 64'hABCD);
    repeat (2) @(negedge clk);
    check("hold_valid", bus.out_valid, 1);
    check("hold_op", bus.out_op, 0);
    check("hold_dst", bus.out_dst, 3);
    check("hold_data_b2", bus.out_data_b, 64'hABCD);

    // ADDI rt=7, imm=0x8001.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.ins       = itype(6'h08, 5'd0, 5'd7, 16'h8001);
    @(negedge clk);
    check("addi_valid", bus.out_valid, 1);
    check("addi_dst", bus.out_dst, 7);
    check("addi_simm", bus.out_simm, 64'hFFFF8001);
    check("addi_zimm", bus.out_zimm, 64'h00008001);

    // SW: store flag, no destination.
    bus.ins = itype(6'h2B, 5'd1, 5'd5, 16'h0004);
    @(negedge clk);
    check("sw_mem_write", bus.out_mem_write, 1);
    check("sw_mem_read", bus.out_mem_read, 0);
    check("sw_dst", bus.out_dst, 0);

    // Flush with JAL presented, then JAL accepted.
    bus.flush = 1'b1;
    bus.ins   = {6'h03, 26'h123456};
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("flush_valid", bus.out_valid, 0);
    bus.flush = 1'b0;
    @(negedge clk);
    check("jal_valid", bus.out_valid, 1);
    check("jal_dst", bus.out_dst, 31);
    check("jal_jpc", bus.out_jpc, 64'h123456);

    // Asynchronous reset mid-stream with a held valid entry.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_dst", bus.out_dst, 0);
    check("arst_in_ready", bus.in_ready, 1);
`ifdef ID_STALL_COUNTER_EN
    check("arst_stall_count", stall_count, 0);
`endif
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.ins       = rtype(6'h00, 5'd5, 5'd2, 5'd1, 6'h21);
    @(negedge clk);
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_data_a", bus.out_data_a, 0);
    check("post_rst_data_b", bus.out_data_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
